// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first,
// with a programmable repeat count (0 = continuous) and idle gap between repetitions.
module seq_pattern_tx #(
  parameter int               WIDTH           = 4,
  parameter logic [WIDTH-1:0] DEFAULT_PATTERN = 4'b1010,
  parameter int               CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap,
  output logic             out,
  output logic             valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] pat_q, pat_n;
  logic [CNT_W-1:0] rep_q, rep_n;
  logic [CNT_W-1:0] gap_q, gap_n;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_n;
  logic [IW-1:0]    idx, idx_n, idx_dec;
  logic             out_n, valid_n, fs_n, busy_n, done_n;
  logic             more;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pat_q       <= DEFAULT_PATTERN;
      rep_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      idx         <= '0;
      out         <= 1'b0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      pat_q       <= pat_n;
      rep_q       <= rep_n;
      gap_q       <= gap_n;
      gap_cnt     <= gap_cnt_n;
      idx         <= idx_n;
      out         <= out_n;
      valid       <= valid_n;
      frame_start <= fs_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    pat_n     = pat_q;
    rep_n     = rep_q;
    gap_n     = gap_q;
    gap_cnt_n = gap_cnt;
    idx_n     = idx;
    out_n     = 1'b0;
    valid_n   = 1'b0;
    fs_n      = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    idx_dec   = idx - IW'(1);
    // A repeat count of zero means continuous: it is never decremented.
    more      = (rep_q == '0) || (rep_q != CNT_W'(1));

    if (abort) begin
      state_n   = IDLE;
      gap_cnt_n = '0;
      idx_n     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = SHIFT;
            pat_n   = pattern;
            rep_n   = repeat_cnt;
            gap_n   = gap;
            idx_n   = MSB_IDX;
            out_n   = pattern[WIDTH-1];
            valid_n = 1'b1;
            fs_n    = 1'b1;
            busy_n  = 1'b1;
          end
        end
        SHIFT: begin
          busy_n = 1'b1;
          if (idx != '0) begin
            idx_n   = idx_dec;
            out_n   = pat_q[idx_dec];
            valid_n = 1'b1;
          end else if (more) begin
            if (rep_q != '0) rep_n = rep_q - CNT_W'(1);
            if (gap_q != '0) begin
              state_n   = GAP;
              gap_cnt_n = gap_q;
            end else begin
              idx_n   = MSB_IDX;
              out_n   = pat_q[WIDTH-1];
              valid_n = 1'b1;
              fs_n    = 1'b1;
            end
          end else begin
            // Final bit of final repetition: no trailing gap before done.
            state_n = IDLE;
            rep_n   = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
        GAP: begin
          busy_n = 1'b1;
          if (gap_cnt <= CNT_W'(1)) begin
            state_n   = SHIFT;
            gap_cnt_n = '0;
            idx_n     = MSB_IDX;
            out_n     = pat_q[WIDTH-1];
            valid_n   = 1'b1;
            fs_n      = 1'b1;
          end else begin
            gap_cnt_n = gap_cnt - CNT_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
